si570_pgm_arbiter: RTL and testbench

Shares the single Si-570 programmer (one I2C engine, two oscillators) among up to NUM_REQ independent requesters, such as the boot-time program controller, a host register interface and a retune agent. It latches per-requester programming requests, grants the programmer round-robin, and drives the programmer's start/select handshake. It returns per-requester done and fault results, and runs a watchdog so a hung programmer cannot stall the other requesters.

---
 rtl/si570_arb_pkg.sv | 21 ++
 rtl/si570_rr_pick.sv | 35 +++
 rtl/si570_pgm_arbiter.sv | 154 +++++++++++++++
 tb/tb_si570_pgm_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/si570_arb_pkg.sv
// Shared types and constants for the Si-570 programmer arbiter.
package si570_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_WAIT,
        ST_FINISH
    } arb_state_t;

    // Cycles after pgm_start during which pgm_done is still stale from the previous operation.
    localparam int GUARD_CYCLES = 2;

    function automatic logic [31:0] timeout_load(input int unsigned clock_freq,
                                                 input int unsigned timeout_ms);
        logic [63:0] cycles;
        cycles = (64'(clock_freq) / 64'd1000) * 64'(timeout_ms);
        return cycles[31:0];
    endfunction

endpackage

// File: rtl/si570_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after ptr, wrapping.
module si570_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && pending[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
        if (found) begin
            grant[index] = 1'b1;
        end
    end

endmodule

// File: rtl/si570_pgm_arbiter.sv
// Round-robin arbiter sharing one Si-570 programmer among NUM_REQ requesters,
// with per-operation watchdog and per-requester done/fault reporting.
module si570_pgm_arbiter
    import si570_arb_pkg::*;
#(
    parameter int          NUM_REQ    = 3,
    parameter int unsigned CLOCK_FREQ = 200000000,
    parameter int unsigned TIMEOUT_MS = 50
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req_start,
    input  logic [NUM_REQ-1:0] req_target,
    output logic [NUM_REQ-1:0] req_busy,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_fault,
    output logic [NUM_REQ-1:0] grant,
    output logic               pgm_start,
    output logic               which_si570,
    input  logic               pgm_done,
    input  logic               pgm_fault,
    output logic               timeout_seen
);

    localparam int               IDX_W        = $clog2(NUM_REQ);
    localparam logic [31:0]      TIMEOUT_LOAD = timeout_load(CLOCK_FREQ, TIMEOUT_MS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_reg, state_next;
    logic [1:0]         guard_reg, guard_next;
    logic [31:0]        wd_reg, wd_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [NUM_REQ-1:0] pending_reg, pending_next;
    logic [NUM_REQ-1:0] target_reg, target_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [NUM_REQ-1:0] fault_reg, fault_next;
    logic               pgm_start_reg, pgm_start_next;
    logic               which_reg, which_next;
    logic               timeout_seen_reg, timeout_seen_next;
    logic [NUM_REQ-1:0] clear, accept, pick_grant;
    logic [IDX_W-1:0]   pick_index;

    si570_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .pending (pending_reg),
        .ptr     (ptr_reg),
        .grant   (pick_grant),
        .index   (pick_index)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= ST_IDLE;
            guard_reg        <= '0;
            wd_reg           <= '0;
            ptr_reg          <= '0;
            owner_reg        <= '0;
            pending_reg      <= '0;
            target_reg       <= '0;
            grant_reg        <= '0;
            done_reg         <= '0;
            fault_reg        <= '0;
            pgm_start_reg    <= 1'b0;
            which_reg        <= 1'b0;
            timeout_seen_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            guard_reg        <= guard_next;
            wd_reg           <= wd_next;
            ptr_reg          <= ptr_next;
            owner_reg        <= owner_next;
            pending_reg      <= pending_next;
            target_reg       <= target_next;
            grant_reg        <= grant_next;
            done_reg         <= done_next;
            fault_reg        <= fault_next;
            pgm_start_reg    <= pgm_start_next;
            which_reg        <= which_next;
            timeout_seen_reg <= timeout_seen_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        guard_next        = guard_reg;
        wd_next           = (wd_reg == '0) ? '0 : wd_reg - 32'd1;
        ptr_next          = ptr_reg;
        owner_next        = owner_reg;
        grant_next        = grant_reg;
        done_next         = '0;
        fault_next        = fault_reg;
        pgm_start_next    = 1'b0;
        which_next        = which_reg;
        timeout_seen_next = timeout_seen_reg;
        clear             = '0;

        case (state_reg)
            ST_IDLE: begin
                if (|pending_reg) begin
                    grant_next     = pick_grant;
                    owner_next     = pick_index;
                    which_next     = target_reg[pick_index];
                    pgm_start_next = 1'b1;
                    wd_next        = TIMEOUT_LOAD;
                    guard_next     = '0;
                    ptr_next       = (pick_index == LAST_IDX) ? '0 : pick_index + 1'b1;
                    state_next     = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_reg == 2'(GUARD_CYCLES - 1)) begin
                    state_next = ST_WAIT;
                end else begin
                    guard_next = guard_reg + 2'd1;
                end
            end
            ST_WAIT: begin
                // A real completion beats a simultaneous watchdog expiry.
                if (pgm_done || wd_reg == '0) begin
                    done_next[owner_reg]  = 1'b1;
                    fault_next[owner_reg] = pgm_done ? pgm_fault : 1'b1;
                    timeout_seen_next     = timeout_seen_reg | ~pgm_done;
                    clear[owner_reg]      = 1'b1;
                    grant_next            = '0;
                    state_next            = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A new strobe from the requester being retired re-arms it in the same cycle.
        accept       = req_start & (~pending_reg | clear);
        pending_next = (pending_reg & ~clear) | accept;
        target_next  = (target_reg & ~accept) | (req_target & accept);
    end

    assign req_busy     = pending_reg;
    assign req_done     = done_reg;
    assign req_fault    = fault_reg;
    assign grant        = grant_reg;
    assign pgm_start    = pgm_start_reg;
    assign which_si570  = which_reg;
    assign timeout_seen = timeout_seen_reg;

endmodule

// File: tb/tb_si570_pgm_arbiter.sv
// Self-checking bench for si570_pgm_arbiter: vector table, directed corner cases and
// randomized traffic, every cycle compared against a transaction-level reference model.
module tb_si570_pgm_arbiter;

    localparam int          NREQ  = 3;
    localparam int unsigned CF    = 1000000;
    localparam int unsigned TMS   = 1;
    localparam int          TMO   = 1000;
    localparam int          GUARD = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NREQ-1:0] req_start, req_target;
    logic [NREQ-1:0] req_busy, req_done, req_fault, grant;
    logic            pgm_start, which_si570, pgm_done, pgm_fault, timeout_seen;

    always #5 clk = ~clk;

    si570_pgm_arbiter #(
        .NUM_REQ    (NREQ),
        .CLOCK_FREQ (CF),
        .TIMEOUT_MS (TMS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_start    (req_start),
        .req_target   (req_target),
        .req_busy     (req_busy),
        .req_done     (req_done),
        .req_fault    (req_fault),
        .grant        (grant),
        .pgm_start    (pgm_start),
        .which_si570  (which_si570),
        .pgm_done     (pgm_done),
        .pgm_fault    (pgm_fault),
        .timeout_seen (timeout_seen)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: requests, one operation in flight described by its age.
    logic [2:0]  m_pend, m_tgt, m_grant, m_done, m_fault;
    logic        m_start, m_which, m_tos;
    int          m_ptr, m_owner, m_age;
    bit          m_active, m_finish;
    logic [14:0] exp_bundle;

    typedef struct packed {
        logic [2:0] start;
        logic [2:0] target;
        logic [2:0] fault;
        logic [1:0] n_ops;
        logic [8:0] order;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_bundle();
        return {req_busy, grant, pgm_start, which_si570, req_done, req_fault, timeout_seen};
    endfunction

    task automatic model_reset();
        m_pend = '0; m_tgt = '0; m_grant = '0; m_done = '0; m_fault = '0;
        m_start = 1'b0; m_which = 1'b0; m_tos = 1'b0;
        m_ptr = 0; m_owner = 0; m_age = 0; m_active = 0; m_finish = 0;
        exp_bundle = '0;
    endtask

    task automatic model_step();
        logic [2:0] cleared, free;
        bit         found;
        int         idx;
        cleared = '0;
        m_done  = '0;
        m_start = 1'b0;
        if (!resetn) begin
            model_reset();
            return;
        end
        if (m_active && m_age >= GUARD && (pgm_done || m_age >= TMO)) begin
            m_done[m_owner]  = 1'b1;
            m_fault[m_owner] = pgm_done ? pgm_fault : 1'b1;
            if (!pgm_done) m_tos = 1'b1;
            cleared[m_owner] = 1'b1;
            m_active = 0;
            m_grant  = '0;
            m_finish = 1;
        end else if (m_active) begin
            m_age++;
        end else if (m_finish) begin
            m_finish = 0;
        end else if (m_pend != 0) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && m_pend[idx]) begin
                    found   = 1;
                    m_owner = idx;
                end
            end
            m_active = 1;
            m_age    = 0;
            m_start  = 1'b1;
            m_grant  = '0;
            m_grant[m_owner] = 1'b1;
            m_which  = m_tgt[m_owner];
            m_ptr    = (m_owner + 1) % NREQ;
        end
        free   = ~m_pend | cleared;
        m_pend = m_pend & ~cleared;
        for (int i = 0; i < NREQ; i++) begin
            if (req_start[i] && free[i]) begin
                m_pend[i] = 1'b1;
                m_tgt[i]  = req_target[i];
            end
        end
        exp_bundle = {m_pend, m_grant, m_start, m_which, m_done, m_fault, m_tos};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("outputs", 32'(dut_bundle()), 32'(exp_bundle));
    endtask

    task automatic wait_start(input int limit);
        int k = 0;
        while (pgm_start !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        check("pgm_start_wait", 32'(pgm_start), 32'd1);
    endtask

    task automatic wait_done(input int limit, input logic [2:0] who);
        int k = 0;
        while ((req_done & who) == 3'b000 && k < limit) begin
            tick();
            k++;
        end
        check("req_done_wait", 32'(req_done & who), 32'(who));
    endtask

    initial begin
        logic [2:0] who;
        int         t0, cnt, starts;

        // {start, target, fault, ops, grant order (first op in low 3 bits)}
        vecs[0] = '{start: 3'b111, target: 3'b101, fault: 3'b000, n_ops: 2'd3, order: 9'b100_010_001};
        vecs[1] = '{start: 3'b001, target: 3'b000, fault: 3'b001, n_ops: 2'd1, order: 9'b000_000_001};
        vecs[2] = '{start: 3'b101, target: 3'b100, fault: 3'b000, n_ops: 2'd2, order: 9'b000_001_100};
        vecs[3] = '{start: 3'b011, target: 3'b010, fault: 3'b011, n_ops: 2'd2, order: 9'b000_001_010};
        vecs[4] = '{start: 3'b110, target: 3'b011, fault: 3'b010, n_ops: 2'd2, order: 9'b000_100_010};

        resetn = 1'b0; req_start = '0; req_target = '0; pgm_done = 1'b0; pgm_fault = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_state", 32'(dut_bundle()), 32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        // Vector table: round-robin order, target select, fault propagation.
        for (int v = 0; v < 5; v++) begin
            req_start = vecs[v].start; req_target = vecs[v].target;
            tick();
            req_start = '0;
            for (int k = 0; k < int'(vecs[v].n_ops); k++) begin
                who = vecs[v].order[k*3 +: 3];
                wait_start(20);
                check("vec_grant", 32'(grant), 32'(who));
                check("vec_which", 32'(which_si570), 32'(|(who & vecs[v].target)));
                tick(); tick();
                pgm_done = 1'b1; pgm_fault = |(who & vecs[v].fault);
                tick();
                pgm_done = 1'b0; pgm_fault = 1'b0;
                check("vec_done", 32'(req_done), 32'(who));
                check("vec_fault", 32'(|(req_fault & who)), 32'(|(who & vecs[v].fault)));
            end
            repeat (3) tick();
        end

        // Single request: exact cycle timing.
        req_start = 3'b010; req_target = 3'b010;
        tick();
        req_start = '0;
        check("single_busy_n1", 32'(req_busy), 32'b010);
        tick();
        check("single_start_n2", 32'({grant, pgm_start, which_si570}), 32'({3'b010, 1'b1, 1'b1}));
        repeat (8) tick();
        pgm_done = 1'b1;
        tick();
        pgm_done = 1'b0;
        check("single_done_n11", 32'({req_done, req_fault[1], req_busy}), 32'({3'b010, 1'b0, 3'b000}));
        repeat (3) tick();

        // Guard: stale pgm_done in the pgm_start cycle and the next one is ignored.
        req_start = 3'b001; req_target = 3'b000;
        tick();
        req_start = '0;
        tick();
        check("guard_start", 32'(pgm_start), 32'd1);
        pgm_done = 1'b1; pgm_fault = 1'b1;
        tick();
        req_start = 3'b001; req_target = 3'b001;
        tick();
        req_start = '0; pgm_done = 1'b0; pgm_fault = 1'b0;
        check("guard_no_done_n4", 32'(req_done), 32'd0);
        tick();
        check("guard_no_done_n5", 32'(req_done), 32'd0);
        tick();
        pgm_done = 1'b1;
        tick();
        pgm_done = 1'b0;
        check("guard_done", 32'({req_done, req_fault[0]}), 32'({3'b001, 1'b0}));
        cnt = 0; starts = 0;
        repeat (15) begin
            tick();
            if (req_done[0]) cnt++;
            if (pgm_start) starts++;
        end
        check("dup_extra_done", 32'(cnt), 32'd0);
        check("dup_extra_start", 32'(starts), 32'd0);
        check("dup_busy", 32'(req_busy), 32'd0);

        // Watchdog expiry, queued requester proceeds, re-request at retirement.
        req_start = 3'b001; req_target = 3'b001;
        tick();
        req_start = 3'b010; req_target = 3'b010;
        tick();
        req_start = '0;
        check("wd_start", 32'({pgm_start, grant}), 32'({1'b1, 3'b001}));
        t0 = cyc;
        wait_done(TMO + 100, 3'b001);
        check("wd_latency", 32'(cyc - t0), 32'(TMO + 1));
        check("wd_fault", 32'({req_fault[0], timeout_seen}), 32'b11);
        wait_start(10);
        check("wd_next_grant", 32'({grant, which_si570}), 32'({3'b010, 1'b1}));
        tick(); tick();
        pgm_done = 1'b1;
        tick();
        pgm_done = 1'b0;
        check("wd_next_done", 32'({req_done, req_fault[1], timeout_seen}), 32'({3'b010, 1'b0, 1'b1}));
        req_start = 3'b010; req_target = 3'b000;
        tick();
        req_start = '0;
        check("rearm_busy", 32'(req_busy), 32'b010);
        wait_start(10);
        check("rearm_grant", 32'({grant, which_si570}), 32'({3'b010, 1'b0}));
        tick(); tick();
        pgm_done = 1'b1;
        tick();
        pgm_done = 1'b0;
        check("rearm_done", 32'(req_done), 32'b010);
        repeat (3) tick();

        // Asynchronous reset in the middle of WAIT with another request queued.
        req_start = 3'b100; req_target = 3'b100;
        tick();
        req_start = 3'b001; req_target = 3'b000;
        tick();
        req_start = '0;
        repeat (4) tick();
        #3 resetn = 1'b0;
        #1 check("async_reset", 32'(dut_bundle()), 32'd0);
        model_reset();
        tick(); tick();
        resetn = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (req_done != 3'b000 || pgm_start) cnt++;
        end
        check("post_reset_quiet", 32'(cnt), 32'd0);
        req_start = 3'b001; req_target = 3'b001;
        tick();
        req_start = '0;
        wait_start(10);
        check("post_reset_grant", 32'({grant, which_si570}), 32'({3'b001, 1'b1}));
        tick(); tick();
        pgm_done = 1'b1;
        tick();
        pgm_done = 1'b0;
        check("post_reset_done", 32'({req_done, req_fault[0]}), 32'({3'b001, 1'b0}));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req_start  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            req_target = 3'($urandom_range(0, 7));
            pgm_done   = ($urandom_range(0, 5) == 0);
            pgm_fault  = 1'($urandom_range(0, 1));
            tick();
        end
        req_start = '0; pgm_done = 1'b0; pgm_fault = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
